bg_cpu_access: RTL

- CPU-side responder for background tile RAM (lo and hi byte banks).
- Accepts Z80 read and write requests to the background RAM.
- Holds the Z80 in wait until the video timing grants a CPU slot, then performs exactly one RAM access. For reads, it returns the latched data.
- Sits between the Z80 bus decode and port B of the two background RAM banks. It replaces the free-running wait shifter with a slot-synchronised handshake.

---
 rtl/bg_cpu_access.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bg_cpu_access.sv
// bg_cpu_access: Z80-side responder for the background tile RAM (lo/hi banks).
// A Z80 request is latched, the CPU is held in WAIT until the video timing
// has offered MIN_WAIT+1 CPU slots, then exactly one port-B access is made.
// Reads return the captured bank data on cpu_dout; WAIT releases once done.
//
// Handshake: a request is "req" (chip select and strobe both active). It is
// accepted only on its rising edge in IDLE. It is completed when the FSM
// reaches DONE. The Z80 must then drop req before another access is accepted.
module bg_cpu_access #(
  parameter int MIN_WAIT   = 2,  // slot_en pulses skipped before the access (0..7)
  parameter int RD_LATENCY = 1   // cycles from ram_addr to valid ram_q (1..3)
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        z80_wr_n,
  input  logic        z80_rd_n,
  input  logic        bgram_1_n,
  input  logic        bgram_2_n,
  input  logic        slot_en,
  input  logic [7:0]  ram_q_lo,
  input  logic [7:0]  ram_q_hi,
  output logic        cpu_wait_n,
  output logic [7:0]  cpu_dout,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_we_lo,
  output logic        ram_we_hi
);

  localparam logic [2:0] MIN_WAIT_C = 3'(MIN_WAIT);
  localparam logic [1:0] LAT_LAST_C = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    ACCESS    = 3'd2,
    RDCAP     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  lat_q, lat_d;
  logic        req_prev_q, req_prev_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        hi_q, hi_d;
  logic        wr_q, wr_d;

  logic        req;
  logic        req_edge;
  logic        we_lo_c;
  logic        we_hi_c;

  // Only the low 11 address bits reach the RAM.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[15:11];

  assign req      = (!bgram_1_n || !bgram_2_n) && (!z80_rd_n || !z80_wr_n);
  assign req_edge = req && !req_prev_q;

  // Next-state logic: request latch, slot counting, read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    req_prev_d = req;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    hi_d       = hi_q;
    wr_d       = wr_q;
    we_lo_c    = 1'b0;
    we_hi_c    = 1'b0;
    case (state_q)
      IDLE: begin
        // A slot_en coincident with the edge is deliberately not counted.
        if (req_edge) begin
          addr_d  = cpu_addr[10:0];
          wdata_d = cpu_din;
          hi_d    = !bgram_2_n && bgram_1_n;  // lo bank wins when both are low
          wr_d    = !z80_wr_n;
          cnt_d   = 3'd0;
          state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (slot_en) begin
          if (cnt_q == MIN_WAIT_C) begin
            lat_d   = 2'd0;
            state_d = ACCESS;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ACCESS: begin
        we_lo_c = wr_q && !hi_q;
        we_hi_c = wr_q && hi_q;
        lat_d   = 2'd0;
        state_d = wr_q ? DONE : RDCAP;
      end
      RDCAP: begin
        if (lat_q == LAT_LAST_C) begin
          dout_d  = hi_q ? ram_q_hi : ram_q_lo;
          state_d = DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      DONE: begin
        // A request held high is never re-executed.
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      lat_q      <= 2'd0;
      req_prev_q <= 1'b0;
      addr_q     <= 11'd0;
      wdata_q    <= 8'd0;
      dout_q     <= 8'd0;
      hi_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      req_prev_q <= req_prev_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      hi_q       <= hi_d;
      wr_q       <= wr_d;
    end
  end

  // Outputs: WAIT is combinational so it drops in the request cycle; the
  // write strobes are gated by reset so a reset during ACCESS suppresses them.
  always_comb begin
    cpu_wait_n = !(req && (state_q != DONE));
    cpu_dout   = dout_q;
    ram_addr   = addr_q;
    ram_dout   = wdata_q;
    ram_we_lo  = we_lo_c && !reset;
    ram_we_hi  = we_hi_c && !reset;
  end

endmodule
